dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters:
  - the pipeline MEM stage, driven from the EX/MEM register outputs (alu result as address, B operand as write data);
  - a program/data loader port.
- Sequences fixed-latency memory accesses and stalls the pipeline until its access completes.
- Sits between the EX/MEM register and the data memory, ahead of the MEM/WB register.

Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MEM_LAT, 2, memory access latency in cycles (>=1)
- STARVE_MAX, 4, consecutive pipeline grants tolerated while the loader waits

Ports:
- clk1  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_memread  in  1  MEM-stage read request
- pipe_memwrite  in  1  MEM-stage write request
- pipe_addr  in  ADDR_W  MEM-stage address
- pipe_wdata  in  DATA_W  MEM-stage store data
- pipe_stall  out  1  freeze the pipeline this cycle
- pipe_rdata  out  DATA_W  load data, valid in the pipe done cycle
- ld_req  in  1  loader request (level)
- ld_we  in  1  loader write enable
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  one-cycle pulse: loader request accepted
- ld_rvalid  out  1  one-cycle pulse: ld_rdata valid
- ld_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe (one cycle)
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last busy cycle

Behaviour:
- Definitions:
  - pipe_req = pipe_memread | pipe_memwrite.
  - If both are high, the access is a write.
- States: IDLE, BUSY, DONE. Owner register: PIPE or LD.
- IDLE, arbitration at the clock edge:
  - pipe_req & !(ld_req & starve_cnt==STARVE_MAX) -> PIPE;
  - else if ld_req -> LD;
  - else stay in IDLE.
- On grant:
  - next state BUSY, cnt = MEM_LAT;
  - mem_en=1, mem_we/mem_addr/mem_wdata registered from the winner, held for exactly the first BUSY cycle (T0), then mem_en=0.
- Loader grant: ld_gnt pulses in T0. The loader must advance or drop ld_req before the state returns to IDLE.
- BUSY:
  - cnt decrements each cycle.
  - In the cycle with cnt==1 (T0+MEM_LAT-1), mem_rdata is sampled at the edge:
    - PIPE owner -> pipe_rdata;
    - LD owner with a read -> ld_rdata.
  - Next state DONE.
- DONE (one cycle, T0+MEM_LAT):
  - PIPE owner: pipe_done=1 and pipe_rdata is valid.
  - LD owner with a read: ld_rvalid=1.
  - No arbitration in this cycle; next state IDLE.
- Stall (combinational): pipe_stall = pipe_req & !(state==DONE & owner==PIPE).
  - Pipe access started from IDLE stalls MEM_LAT+1 cycles.
  - The pipeline advances at the end of the DONE cycle.
- Starvation counter starve_cnt:
  - increments (saturating at STARVE_MAX) on each PIPE grant while ld_req=1;
  - clears on an LD grant, or in any IDLE cycle with ld_req=0.
- pipe_rdata and ld_rdata hold their value until the next capture.
- Writes capture no read data.
- Reset, at any time including mid-access:
  - state=IDLE, cnt=0, starve_cnt=0;
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - ld_gnt=0, ld_rvalid=0, pipe_rdata=0, ld_rdata=0.
  - The in-flight access is abandoned; no done or rvalid pulse is produced.
  - pipe_stall still equals pipe_req during and after reset.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, BUSY, DONE};
  - owner enum {OWN_PIPE, OWN_LD};
  - width constants ADDR_W and DATA_W.
- Single module; no sub-module needed. The counter and the arbitration logic are small enough to stay inline.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Reset: hold rst 2 cycles with pipe_memread=1 -> mem_en=0, ld_gnt=0, pipe_rdata=0x00, pipe_stall=1; after reset the grant occurs on the first edge.
- Pipe read: addr 0x12 at cycle R, memory returns 0xA5.
  - mem_en=1, we=0, addr=0x12 in R+1 only.
  - pipe_stall=1 in R..R+2; pipe_stall=0 and pipe_rdata=0xA5 in R+3.
- Pipe write: addr 0x30, data 0x7E -> mem_we=1, mem_wdata=0x7E in R+1; stall in R..R+2; pipe_rdata unchanged.
- Contention: pipe read 0x05 and loader read 0x40 both in cycle R.
  - Pipe is served first: R+3 is the DONE cycle, R+4 is IDLE.
  - Loader is granted at the end of R+4: ld_gnt in R+5, ld_rvalid with the 0x40 data in R+7.
- Starvation: pipe issues a new request every IDLE cycle while ld_req is held.
  - After 4 pipe grants, the 5th arbitration goes to LD: ld_gnt=1, pipe_stall extended by 3 cycles.
  - starve_cnt returns to 0.
- Reset mid-access: assert rst in cycle T0+1 of a pipe read -> next cycle state IDLE, no DONE pulse; pipe_stall=1 until re-grant and completion.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Width defaults and the FSM/owner encodings live here.
package dmem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OWN_PIPE,
    OWN_LD
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the MEM stage and the loader.
// Fixed-latency accesses; the loader wins after STARVE_MAX pipe grants.
module dmem_arbiter #(
  parameter int ADDR_W     = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W     = dmem_arb_pkg::DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              pipe_memread,
  input  logic              pipe_memwrite,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_arb_pkg::*;

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  state_t           state;
  state_t           state_d;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             acc_we;
  logic             pipe_req;
  logic             pipe_win;
  logic             ld_win;
  logic             last_busy;
  logic             starved;

  assign pipe_req  = pipe_memread | pipe_memwrite;
  assign last_busy = (state == BUSY) && (cnt == CNT_W'(1));
  assign starved   = ld_req && (starve_cnt == STV_W'(STARVE_MAX));

  assign pipe_stall = pipe_req &
                      !(state == DONE && owner == OWN_PIPE);

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    pipe_win = 1'b0;
    ld_win   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pipe_req && !starved) pipe_win = 1'b1;
        else if (ld_req)          ld_win   = 1'b1;
        if (pipe_win || ld_win) state_d = BUSY;
      end
      BUSY: begin
        if (last_busy) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes default low so mem_en/ld_gnt/ld_rvalid are single-cycle pulses.
  always_ff @(posedge clk1) begin
    if (rst) begin
      owner      <= OWN_PIPE;
      acc_we     <= 1'b0;
      cnt        <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ld_gnt     <= 1'b0;
      ld_rvalid  <= 1'b0;
      pipe_rdata <= '0;
      ld_rdata   <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      ld_gnt    <= 1'b0;
      ld_rvalid <= 1'b0;
      if (state == BUSY) cnt <= cnt - 1'b1;
      if (pipe_win) begin
        owner     <= OWN_PIPE;
        acc_we    <= pipe_memwrite;
        cnt       <= CNT_W'(MEM_LAT);
        mem_en    <= 1'b1;
        mem_we    <= pipe_memwrite;
        mem_addr  <= pipe_addr;
        mem_wdata <= pipe_wdata;
      end
      if (ld_win) begin
        owner     <= OWN_LD;
        acc_we    <= ld_we;
        cnt       <= CNT_W'(MEM_LAT);
        mem_en    <= 1'b1;
        mem_we    <= ld_we;
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
        ld_gnt    <= 1'b1;
      end
      if (last_busy && !acc_we) begin
        if (owner == OWN_PIPE) begin
          pipe_rdata <= mem_rdata;
        end else begin
          ld_rdata  <= mem_rdata;
          ld_rvalid <= 1'b1;
        end
      end
      if (ld_win || (state == IDLE && !ld_req))
        starve_cnt <= '0;
      else if (pipe_win && starve_cnt != STV_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int MEM_LAT = 2;
  localparam int SMAX    = 4;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          pipe_memread;
  logic          pipe_memwrite;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;
  logic [DW-1:0] pipe_rdata;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk1         (clk1),
    .rst          (rst),
    .pipe_memread (pipe_memread),
    .pipe_memwrite(pipe_memwrite),
    .pipe_addr    (pipe_addr),
    .pipe_wdata   (pipe_wdata),
    .pipe_stall   (pipe_stall),
    .pipe_rdata   (pipe_rdata),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [7:0] init_val(int i);
    if (i == 'h12) return 8'hA5;
    if (i == 'h40) return 8'h3C;
    return 8'(i * 37 + 11);
  endfunction

  // Memory: data valid only in the last busy cycle, junk otherwise.
  logic [7:0] tbmem [256];
  logic [7:0] lat_addr  = '0;
  int         rd_cd     = 0;
  bit         mem_ready = 1'b0;

  assign mem_rdata = (rd_cd == 1) ? tbmem[lat_addr] : 8'h5A;

  always @(posedge clk1) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      lat_addr <= mem_addr;
      rd_cd    <= MEM_LAT - 1;
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
    end else if (rd_cd > 0) begin
      rd_cd <= rd_cd - 1;
    end
  end

  // Transaction model: one access in flight, timed from its T0 cycle.
  logic [7:0] ref_mem [256];
  bit         ref_ready = 1'b0;
  int         cyc    = 0;
  int         t0     = 0;
  int         starve = 0;
  bit         busy   = 1'b0;
  bit         m_pipe = 1'b0;
  bit         m_we   = 1'b0;
  logic [7:0] m_addr  = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] e_prd   = '0;
  logic [7:0] e_lrd   = '0;
  bit         pipe_adv = 1'b0;
  bit         ld_adv   = 1'b0;
  bit         chk_en   = 1'b0;

  task automatic grant(bit p, bit w, logic [7:0] a, logic [7:0] d);
    busy    = 1'b1;
    t0      = cyc + 1;
    m_pipe  = p;
    m_we    = w;
    m_addr  = a;
    m_wdata = d;
    if (w) ref_mem[a] = d;
  endtask

  always @(posedge clk1) begin
    if (!ref_ready) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_ready = 1'b1;
    end
    pipe_adv = 1'b0;
    ld_adv   = busy && cyc == t0 && !m_pipe;
    if (rst) begin
      busy   = 1'b0;
      starve = 0;
      e_prd  = '0;
      e_lrd  = '0;
    end else if (busy) begin
      if (cyc == t0 + MEM_LAT - 1 && !m_we) begin
        if (m_pipe) e_prd = ref_mem[m_addr];
        else        e_lrd = ref_mem[m_addr];
      end
      if (cyc == t0 + MEM_LAT) begin
        busy     = 1'b0;
        pipe_adv = m_pipe;
      end
    end else begin
      if ((pipe_memread || pipe_memwrite) &&
          !(ld_req && starve == SMAX)) begin
        grant(1'b1, pipe_memwrite, pipe_addr, pipe_wdata);
        starve = ld_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end else if (ld_req) begin
        grant(1'b0, ld_we, ld_addr, ld_wdata);
        starve = 0;
      end else begin
        starve = 0;
      end
    end
    cyc++;
  end

  task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               n, got, exp, cyc);
    end
  endtask

  always @(negedge clk1) begin
    bit done_e;
    bit en_e;
    if (chk_en) begin
      done_e = busy && cyc == t0 + MEM_LAT;
      en_e   = busy && cyc == t0;
      chk("pipe_stall", pipe_stall,
          (pipe_memread | pipe_memwrite) && !(done_e && m_pipe));
      chk("mem_en", mem_en, en_e);
      if (en_e) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("ld_gnt", ld_gnt, en_e && !m_pipe);
      chk("ld_rvalid", ld_rvalid, done_e && !m_pipe && !m_we);
      chk("pipe_rdata", pipe_rdata, e_prd);
      chk("ld_rdata", ld_rdata, e_lrd);
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic new_ld();
    ld_we    = 1'($urandom_range(0, 1));
    ld_addr  = 8'($urandom_range(0, 15));
    ld_wdata = 8'($urandom);
  endtask

  initial begin
    int r;
    rst           = 1'b1;
    pipe_memread  = 1'b1;
    pipe_memwrite = 1'b0;
    pipe_addr     = 8'h12;
    pipe_wdata    = 8'h00;
    ld_req        = 1'b0;
    ld_we         = 1'b0;
    ld_addr       = 8'h00;
    ld_wdata      = 8'h00;
    chk_en        = 1'b1;

    @(negedge clk1);
    chk("rst_mem_en", mem_en, 8'h00);
    chk("rst_ld_gnt", ld_gnt, 8'h00);
    chk("rst_pipe_rdata", pipe_rdata, 8'h00);
    chk("rst_pipe_stall", pipe_stall, 8'h01);

    tick(); rst = 1'b0;
    @(negedge clk1); chk("rd_stall_r0", pipe_stall, 8'h01);
    tick(); @(negedge clk1);
    chk("rd_en_r1", mem_en, 8'h01);
    chk("rd_we_r1", mem_we, 8'h00);
    chk("rd_addr_r1", mem_addr, 8'h12);
    tick(); @(negedge clk1);
    chk("rd_en_r2", mem_en, 8'h00);
    chk("rd_stall_r2", pipe_stall, 8'h01);
    tick(); @(negedge clk1);
    chk("rd_stall_r3", pipe_stall, 8'h00);
    chk("rd_data_r3", pipe_rdata, 8'hA5);

    tick();
    pipe_memread  = 1'b0;
    pipe_memwrite = 1'b1;
    pipe_addr     = 8'h30;
    pipe_wdata    = 8'h7E;
    @(negedge clk1); chk("wr_stall_r0", pipe_stall, 8'h01);
    tick(); @(negedge clk1);
    chk("wr_we_r1", mem_we, 8'h01);
    chk("wr_wdata_r1", mem_wdata, 8'h7E);
    tick(); tick(); @(negedge clk1);
    chk("wr_stall_r3", pipe_stall, 8'h00);
    chk("wr_rdata_hold", pipe_rdata, 8'hA5);

    tick();
    pipe_memwrite = 1'b0;
    pipe_memread  = 1'b1;
    pipe_addr     = 8'h05;
    ld_req        = 1'b1;
    ld_we         = 1'b0;
    ld_addr       = 8'h40;
    repeat (3) tick();
    @(negedge clk1); chk("ct_pipe_done", pipe_stall, 8'h00);
    tick(); pipe_memread = 1'b0;
    tick(); @(negedge clk1); chk("ct_ld_gnt", ld_gnt, 8'h01);
    tick(); ld_req = 1'b0;
    tick(); @(negedge clk1);
    chk("ct_ld_rvalid", ld_rvalid, 8'h01);
    chk("ct_ld_rdata", ld_rdata, 8'h3C);

    tick();
    pipe_memread = 1'b1;
    pipe_addr    = 8'h07;
    ld_req       = 1'b1;
    ld_addr      = 8'h41;
    repeat (17) tick();
    @(negedge clk1); chk("sv_ld_gnt", ld_gnt, 8'h01);
    tick(); ld_req = 1'b0;
    tick(); @(negedge clk1); chk("sv_stall_ext", pipe_stall, 8'h01);
    repeat (4) tick();
    @(negedge clk1); chk("sv_pipe_done", pipe_stall, 8'h00);
    tick(); pipe_memread = 1'b0;

    tick();
    pipe_memread = 1'b1;
    pipe_addr    = 8'h12;
    tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk1);
    chk("mr_stall", pipe_stall, 8'h01);
    chk("mr_mem_en", mem_en, 8'h00);
    chk("mr_rdata", pipe_rdata, 8'h00);
    repeat (3) tick();
    @(negedge clk1);
    chk("mr_done", pipe_stall, 8'h00);
    chk("mr_data", pipe_rdata, 8'hA5);
    tick(); pipe_memread = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      tick();
      rst = ($urandom_range(0, 249) == 0);
      if (!(pipe_memread || pipe_memwrite) || pipe_adv) begin
        r             = $urandom_range(0, 9);
        pipe_memread  = (r >= 4 && r <= 6) || r == 9;
        pipe_memwrite = (r >= 7);
        pipe_addr     = 8'($urandom_range(0, 15));
        pipe_wdata    = 8'($urandom);
      end
      if (ld_adv) begin
        ld_req = 1'($urandom_range(0, 1));
        new_ld();
      end else if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_req = 1'b1;
        new_ld();
      end
    end

    tick();
    rst           = 1'b0;
    pipe_memread  = 1'b0;
    pipe_memwrite = 1'b0;
    ld_req        = 1'b0;
    repeat (8) tick();
    @(negedge clk1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
